piarb_rr_sch: RTL
=================

PIARB_RR_SCH -- requirements
Module: piarb_rr_sch

Interface
REQ-001 SHALL have parameter QUEUE_ID_NBITS, default 5, width of a PU queue id.
REQ-002 SHALL have parameter NUM_QUEUES, default 32, number of PU queues (at most 2**QUEUE_ID_NBITS).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum dequeues issued but not yet acknowledged (at most 15).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sch_enable  in  1  level; permits new dequeue issue.
- qm_enq_ack  in  1  queue manager accepted an enqueue.
- qm_enq_to_empty  in  1  that enqueue hit an empty queue.
- qm_enq_ack_qid  in  QUEUE_ID_NBITS  queue of that enqueue.
- sch_deq_depth_ack  in  1  queue manager completed a dequeue.
- sch_deq_depth_qid  in  QUEUE_ID_NBITS  queue of that completion.
- sch_deq_depth_empty  in  1  queue is empty after that dequeue.
- pu_ready  in  NUM_QUEUES  per-PU ready mask.
- sch_deq  out  1  registered one-cycle dequeue request.
- sch_deq_qid  out  QUEUE_ID_NBITS  queue of the dequeue request.
- active_map  out  NUM_QUEUES  registered non-empty queue bitmap.
- outstanding  out  4  issued-minus-acked count.
- sch_busy  out  1  state is not IDLE.
- err_spurious_ack  out  1  sticky error flag.
- err_dup_enq  out  1  sticky error flag.

Function
REQ-005 SHALL set active[q] on qm_enq_ack&qm_enq_to_empty with q=qm_enq_ack_qid.
REQ-006 SHALL clear active[q] on sch_deq_depth_ack&sch_deq_depth_empty with q=sch_deq_depth_qid.
REQ-007 SHALL let set win over clear when REQ-005 and REQ-006 hit the same q in the same cycle.
REQ-008 SHALL hold a pending[q] bit: set at the edge where sch_deq asserts for q; cleared by sch_deq_depth_ack for q.
REQ-009 SHALL define eligible[q] = active[q] & ~pending[q] & pu_ready[q], evaluated from registered state.
REQ-010 SHALL choose the first eligible queue searching upward from last_grant+1 with wrap past NUM_QUEUES-1 to 0; last_grant resets to NUM_QUEUES-1, so queue 0 has priority first.
REQ-011 SHALL issue when state==RUN, any eligible bit is set, and outstanding<MAX_OUTSTANDING.
REQ-012 On issue, SHALL assert sch_deq for exactly one cycle on the next edge, with sch_deq_qid = selected q, and update last_grant = q.
REQ-013 SHALL hold sch_deq_qid at its last value when sch_deq=0.
REQ-014 SHALL issue at most one dequeue per cycle; back-to-back issue to different queues SHALL be allowed.
REQ-015 SHALL never issue to a queue with pending set; a pending queue is skipped, not waited on.
REQ-016 outstanding SHALL be +1 on issue, -1 on a valid ack, unchanged when both occur in the same cycle, and never wrap.
REQ-017 A sch_deq_depth_ack with pending[q]=0 SHALL set err_spurious_ack and SHALL NOT change outstanding, pending, or active.
REQ-018 qm_enq_to_empty for a queue with active=1 SHALL set err_dup_enq; active stays 1.
REQ-019 SHALL implement states IDLE, RUN, DRAIN:
- IDLE to RUN when sch_enable=1.
- RUN to DRAIN when sch_enable=0.
- DRAIN to IDLE when outstanding==0.
- DRAIN to RUN when sch_enable=1.
REQ-020 SHALL process enqueue and ack events in every state.

Reset
REQ-021 rst_n low SHALL asynchronously force: state=IDLE, sch_deq=0, sch_deq_qid=0, active_map=0, pending=0, outstanding=0, last_grant=NUM_QUEUES-1, both error flags=0.
REQ-022 Reset mid-operation SHALL discard in-flight dequeues; acks arriving after reset release are treated as spurious.

Structure
REQ-023 The shared package piarb_pkg SHALL hold QUEUE_ID_NBITS, NUM_QUEUES, MAX_OUTSTANDING defaults and the state encoding.
REQ-024 SHALL use one combinational sub-module, piarb_rr_pick (request mask, last_grant in; grant valid and grant id out).

Verification
REQ-025 Reset release, sch_enable=1, pu_ready all 1, enq_to_empty on q=3 -> active_map[3]=1 next cycle; sch_deq=1 with qid=3 one cycle later; pending[3] set.
REQ-026 Queues 0, 5, 31 active, last_grant=5, nothing pending -> grants in order 31, 0, 5, one per cycle, with outstanding reaching 3.
REQ-027 MAX_OUTSTANDING=4, six queues active, no acks -> exactly 4 sch_deq pulses, then stall; one ack -> exactly one more issue.
REQ-028 Same-cycle ack(q=7, empty=1) and enq_to_empty(q=7) -> active[7] remains 1 and q=7 is re-issued after pending clears.
REQ-029 sch_enable drops with outstanding=2 -> state DRAIN with no new sch_deq; two acks -> IDLE, sch_busy=0.
REQ-030 Ack for a non-pending q=9 -> err_spurious_ack=1 (sticky); outstanding unchanged; rst_n pulse -> all outputs at reset values.

Source files
------------

// File: rtl/piarb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : piarb_pkg                                                   |
// | Brief  : Shared defaults and state encoding for the PU arbiter.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package piarb_pkg;

  localparam int unsigned C_QUEUE_ID_NBITS  = 5;
  localparam int unsigned C_NUM_QUEUES      = 32;
  localparam int unsigned C_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sch_state_e;

endpackage
`default_nettype wire

// File: rtl/piarb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : piarb_rr_pick                                               |
// | Brief  : Combinational round-robin pick, searching up from last+1.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module piarb_rr_pick
  import piarb_pkg::*;
#(
  parameter int unsigned QUEUE_ID_NBITS = C_QUEUE_ID_NBITS,
  parameter int unsigned NUM_QUEUES     = C_NUM_QUEUES
) (
  input  logic [NUM_QUEUES-1:0]     req,
  input  logic [QUEUE_ID_NBITS-1:0] last_grant,
  output logic                      gnt_valid,
  output logic [QUEUE_ID_NBITS-1:0] gnt_id
);

  // Walk from the farthest offset down to +1 so the nearest request overwrites.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = last_grant;
    for (int i = int'(NUM_QUEUES); i >= 1; i--) begin
      idx = (int'(last_grant) + i) % int'(NUM_QUEUES);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = QUEUE_ID_NBITS'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/piarb_rr_sch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : piarb_rr_sch                                                |
// | Brief  : Round-robin PU dequeue scheduler with outstanding limit.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module piarb_rr_sch
  import piarb_pkg::*;
#(
  parameter int unsigned QUEUE_ID_NBITS  = C_QUEUE_ID_NBITS,
  parameter int unsigned NUM_QUEUES      = C_NUM_QUEUES,
  parameter int unsigned MAX_OUTSTANDING = C_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sch_enable,
  input  logic                      qm_enq_ack,
  input  logic                      qm_enq_to_empty,
  input  logic [QUEUE_ID_NBITS-1:0] qm_enq_ack_qid,
  input  logic                      sch_deq_depth_ack,
  input  logic [QUEUE_ID_NBITS-1:0] sch_deq_depth_qid,
  input  logic                      sch_deq_depth_empty,
  input  logic [NUM_QUEUES-1:0]     pu_ready,
  output logic                      sch_deq,
  output logic [QUEUE_ID_NBITS-1:0] sch_deq_qid,
  output logic [NUM_QUEUES-1:0]     active_map,
  output logic [3:0]                outstanding,
  output logic                      sch_busy,
  output logic                      err_spurious_ack,
  output logic                      err_dup_enq
);

  localparam logic [QUEUE_ID_NBITS-1:0] C_LAST_GRANT_RST = QUEUE_ID_NBITS'(NUM_QUEUES - 1);
  localparam logic [3:0]                C_MAX_OUT        = 4'(MAX_OUTSTANDING);

  sch_state_e                r_state;
  sch_state_e                w_state_nxt;
  logic [NUM_QUEUES-1:0]     r_active;
  logic [NUM_QUEUES-1:0]     r_pending;
  logic [3:0]                r_outstanding;
  logic [QUEUE_ID_NBITS-1:0] r_last_grant;
  logic                      r_sch_deq;
  logic [QUEUE_ID_NBITS-1:0] r_sch_deq_qid;
  logic                      r_err_spurious_ack;
  logic                      r_err_dup_enq;

  logic [NUM_QUEUES-1:0]     w_enq_oh;
  logic [NUM_QUEUES-1:0]     w_ack_oh;
  logic [NUM_QUEUES-1:0]     w_gnt_oh;
  logic [NUM_QUEUES-1:0]     w_eligible;
  logic [NUM_QUEUES-1:0]     w_set_oh;
  logic [NUM_QUEUES-1:0]     w_clr_oh;
  logic [NUM_QUEUES-1:0]     w_ack_rel_oh;
  logic                      w_enq_hit;
  logic                      w_ack_valid;
  logic                      w_spurious;
  logic                      w_dup;
  logic                      w_gnt_valid;
  logic                      w_issue;
  logic [QUEUE_ID_NBITS-1:0] w_gnt_id;

  piarb_rr_pick #(
    .QUEUE_ID_NBITS (QUEUE_ID_NBITS),
    .NUM_QUEUES     (NUM_QUEUES)
  ) u_pick (
    .req        (w_eligible),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  // Out-of-range queue ids shift out to an all-zero mask, so they act as no-ops.
  always_comb begin
    w_enq_oh     = NUM_QUEUES'(1) << qm_enq_ack_qid;
    w_ack_oh     = NUM_QUEUES'(1) << sch_deq_depth_qid;
    w_gnt_oh     = NUM_QUEUES'(1) << w_gnt_id;
    w_enq_hit    = qm_enq_ack & qm_enq_to_empty;
    w_ack_valid  = sch_deq_depth_ack & (|(r_pending & w_ack_oh));
    w_spurious   = sch_deq_depth_ack & ~(|(r_pending & w_ack_oh));
    w_ack_rel_oh = w_ack_valid ? w_ack_oh : '0;
    w_set_oh     = w_enq_hit ? w_enq_oh : '0;
    w_clr_oh     = (w_ack_valid & sch_deq_depth_empty) ? w_ack_oh : '0;
    // A queue drained in this same cycle is legitimately empty again, not a duplicate.
    w_dup        = w_enq_hit & (|(r_active & w_enq_oh & ~w_clr_oh));
    w_eligible   = r_active & ~r_pending & pu_ready;
    w_issue      = (r_state == ST_RUN) & w_gnt_valid & (r_outstanding < C_MAX_OUT);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (sch_enable) w_state_nxt = ST_RUN;
      ST_RUN:   if (!sch_enable) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (sch_enable)                  w_state_nxt = ST_RUN;
        else if (r_outstanding == 4'd0)  w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= ST_IDLE;
      r_active           <= '0;
      r_pending          <= '0;
      r_outstanding      <= 4'd0;
      r_last_grant       <= C_LAST_GRANT_RST;
      r_sch_deq          <= 1'b0;
      r_sch_deq_qid      <= '0;
      r_err_spurious_ack <= 1'b0;
      r_err_dup_enq      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_active  <= (r_active & ~w_clr_oh) | w_set_oh;
      r_pending <= (r_pending & ~w_ack_rel_oh) | (w_issue ? w_gnt_oh : '0);
      if (w_issue && !w_ack_valid) begin
        r_outstanding <= r_outstanding + 4'd1;
      end else if (!w_issue && w_ack_valid && (r_outstanding != 4'd0)) begin
        r_outstanding <= r_outstanding - 4'd1;
      end
      r_sch_deq <= w_issue;
      if (w_issue) begin
        r_sch_deq_qid <= w_gnt_id;
        r_last_grant  <= w_gnt_id;
      end
      if (w_spurious) r_err_spurious_ack <= 1'b1;
      if (w_dup)      r_err_dup_enq      <= 1'b1;
    end
  end

  assign sch_deq          = r_sch_deq;
  assign sch_deq_qid      = r_sch_deq_qid;
  assign active_map       = r_active;
  assign outstanding      = r_outstanding;
  assign sch_busy         = (r_state != ST_IDLE);
  assign err_spurious_ack = r_err_spurious_ack;
  assign err_dup_enq      = r_err_dup_enq;

endmodule
`default_nettype wire
